gshare_branch_predictor: RTL

//  Parametrised two-level global-history conditional branch predictor, the successor to the fixed 2-bit predictor.

---
 rtl/gshare_branch_predictor.sv | 100 ++++++++++
 1 files changed

// File: rtl/gshare_branch_predictor.sv
// Two-level global-history branch predictor: a PC/history hash indexes a table of saturating counters.
// Speculative history shifts at fetch and is repaired from the carried history on mispredict.
module gshare_branch_predictor #(
  parameter int HIST_LEN       = 8,
  parameter int PHT_INDEX_BITS = 10,
  parameter int CTR_BITS       = 2,
  parameter int CTR_INIT       = 2**(CTR_BITS-1),
  parameter int PC_LSB         = 2,
  parameter int HASH_MODE      = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_br_valid,
  input  logic [31:0]               fetch_pc,
  output logic                      pred_ready,
  output logic                      pred_taken,
  output logic [PHT_INDEX_BITS-1:0] pred_pht_index,
  output logic [HIST_LEN-1:0]       pred_ghr,
  input  logic                      upd_valid,
  input  logic                      upd_taken,
  input  logic [PHT_INDEX_BITS-1:0] upd_pht_index,
  input  logic [HIST_LEN-1:0]       upd_ghr,
  input  logic                      upd_mispredict
);
  localparam int ENTRIES = 2**PHT_INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_RST = CTR_BITS'(CTR_INIT);

  typedef enum logic {INIT, READY} state_t;

  state_t                    state;
  logic [PHT_INDEX_BITS-1:0] init_ptr;
  logic [PHT_INDEX_BITS-1:0] idx;
  logic [HIST_LEN-1:0]       spec_ghr;
  logic [CTR_BITS-1:0]       pht [ENTRIES];
  logic [CTR_BITS-1:0]       upd_ctr;
  logic [CTR_BITS-1:0]       upd_next;
  logic                      ready;
  logic                      unused_bits;

  // Hash selection resolved at elaboration; only the chosen slice of fetch_pc is consumed.
  generate
    if (HASH_MODE == 0) begin : g_gshare
      assign idx = fetch_pc[PC_LSB +: PHT_INDEX_BITS] ^ PHT_INDEX_BITS'(spec_ghr);
    end else begin : g_gselect
      assign idx = {fetch_pc[PC_LSB +: PHT_INDEX_BITS-HIST_LEN], spec_ghr};
    end
  endgenerate

  assign unused_bits = ^{fetch_pc, upd_ghr[HIST_LEN-1]};

  assign ready          = (state == READY);
  assign pred_ready     = ready;
  assign pred_taken     = ready & pht[idx][CTR_BITS-1];
  assign pred_pht_index = ready ? idx : '0;
  assign pred_ghr       = ready ? spec_ghr : '0;

  always_comb begin
    upd_ctr  = pht[upd_pht_index];
    upd_next = upd_ctr;
    if (upd_taken) begin
      if (upd_ctr != CTR_MAX) upd_next = upd_ctr + CTR_BITS'(1);
    end else begin
      if (upd_ctr != '0) upd_next = upd_ctr - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_ptr <= '0;
      spec_ghr <= '0;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == '1) state <= READY;
        end
        READY: begin
          // Repair wins; a fetch shift in the same cycle was on the wrong path.
          if (upd_valid && upd_mispredict)
            spec_ghr <= {upd_ghr[HIST_LEN-2:0], upd_taken};
          else if (fetch_br_valid)
            spec_ghr <= {spec_ghr[HIST_LEN-2:0], pred_taken};
        end
        default: state <= INIT;
      endcase
    end
  end

  // Table kept out of the reset branch so it maps to a single-write-port RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT)
        pht[init_ptr] <= CTR_RST;
      else if (upd_valid)
        pht[upd_pht_index] <= upd_next;
    end
  end
endmodule
